// File: rtl/linear_layer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// linear_layer_ctrl_pkg
//
// Shared definitions for the start-token consumers in the Linear_Layer
// dataflow control path.
//
// Contents:
//   state_e                - two-state handshake FSM encoding
//   DEF_MAX_OUTSTANDING    - default bound on in-flight task invocations
//   DEF_CNT_WIDTH          - default width of the completed-invocation counter
//   outstanding_width()    - width needed to hold 0..max_outstanding
// -----------------------------------------------------------------------------
package linear_layer_ctrl_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    localparam int DEF_MAX_OUTSTANDING = 2;
    localparam int DEF_CNT_WIDTH       = 16;

    // The outstanding count must be able to reach max_outstanding itself,
    // hence the +1 before taking the log.
    function automatic int outstanding_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/start_credit_counter.sv
// -----------------------------------------------------------------------------
// start_credit_counter
//
// Up/down counter of task invocations that have been started but have not yet
// reported done. An increment (issue) and a decrement (done) in the same cycle
// cancel out. A done arriving while the count is zero and no issue is
// happening in the same cycle is rejected: it does not touch the count and it
// sets a sticky underflow flag that only reset clears.
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   inc_i         in   one invocation issued this cycle
//   dec_i         in   one done pulse this cycle
//   count_o       out  invocations in flight
//   dec_accept_o  out  this cycle's done pulse is counted
//   underflow_o   out  sticky: a done pulse arrived with nothing in flight
// -----------------------------------------------------------------------------
module start_credit_counter
    import linear_layer_ctrl_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int OW              = outstanding_width(MAX_OUTSTANDING)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [OW-1:0] count_o,
    output logic          dec_accept_o,
    output logic          underflow_o
);

    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    logic [OW-1:0] count_q;
    logic [OW-1:0] count_d;
    logic          underflow_q;
    logic          underflow_d;
    logic          dec_accept;

    always_comb begin
        // A same-cycle issue supplies the credit a done needs, so a done is
        // only rejected when nothing is in flight and nothing is arriving.
        dec_accept  = dec_i && ((count_q != '0) || inc_i);
        count_d     = count_q;
        underflow_d = underflow_q;

        if (inc_i && !dec_accept) begin
            // The consumer never pops at full credit, so the saturation guard
            // only protects against a misbehaving caller.
            if (count_q != MAX_CNT) begin
                count_d = count_q + OW'(1);
            end
        end else if (dec_accept && !inc_i) begin
            count_d = count_q - OW'(1);
        end

        if (dec_i && !dec_accept) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o      = count_q;
    assign dec_accept_o = dec_accept;
    assign underflow_o  = underflow_q;

endmodule

// File: rtl/linear_layer_start_token_consumer.sv
// -----------------------------------------------------------------------------
// linear_layer_start_token_consumer
//
// Read side of a start_for_* token FIFO. Each popped token becomes exactly one
// ap_start/ap_ready handshake on the downstream PE task. Invocations started
// but not yet done are tracked so that no more than MAX_OUTSTANDING are in
// flight; done pulses with nothing in flight raise a sticky error.
//
// Ports:
//   ap_clk         in   clock
//   ap_rst         in   synchronous active-high reset
//   start_empty_n  in   FIFO holds at least one token
//   start_dout     in   token at the FIFO head
//   start_read     out  pop strobe to the FIFO (combinational)
//   task_ap_start  out  start request to the PE task (from state register)
//   task_ap_ready  in   task accepted the start
//   task_ap_done   in   one-cycle completion pulse from the task
//   task_token     out  token bound to the current or most recent start
//   outstanding    out  invocations started and not yet done
//   done_count     out  accepted done pulses, wrapping
//   err_underflow  out  sticky: done pulse seen with nothing in flight
//   drained        out  idle, nothing in flight, FIFO empty
// -----------------------------------------------------------------------------
module linear_layer_start_token_consumer
    import linear_layer_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH      = 1,
    parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter  int CNT_WIDTH       = DEF_CNT_WIDTH,
    localparam int OW              = outstanding_width(MAX_OUTSTANDING)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  start_empty_n,
    input  logic [DATA_WIDTH-1:0] start_dout,
    output logic                  start_read,
    output logic                  task_ap_start,
    input  logic                  task_ap_ready,
    input  logic                  task_ap_done,
    output logic [DATA_WIDTH-1:0] task_token,
    output logic [OW-1:0]         outstanding,
    output logic [CNT_WIDTH-1:0]  done_count,
    output logic                  err_underflow,
    output logic                  drained
);

    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   token_q;
    logic [CNT_WIDTH-1:0]    done_count_q;
    logic [CNT_WIDTH-1:0]    done_count_d;
    logic [OW-1:0]           outstanding_w;
    logic                    pop;
    logic                    issue;
    logic                    done_accept;
    logic                    underflow_w;

    // Pop only with a free credit; the reset term keeps the FIFO intact while
    // reset is held, so the head token survives to be popped afterwards.
    assign pop   = (state_q == S_IDLE) && start_empty_n &&
                   (outstanding_w < MAX_CNT) && !ap_rst;
    assign issue = (state_q == S_ISSUE) && task_ap_ready;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            token_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        token_q <= start_dout;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (task_ap_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    start_credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk          (ap_clk),
        .rst          (ap_rst),
        .inc_i        (issue),
        .dec_i        (task_ap_done),
        .count_o      (outstanding_w),
        .dec_accept_o (done_accept),
        .underflow_o  (underflow_w)
    );

    always_comb begin
        done_count_d = done_count_q;
        if (done_accept) begin
            done_count_d = done_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            done_count_q <= '0;
        end else begin
            done_count_q <= done_count_d;
        end
    end

    assign start_read    = pop;
    assign task_ap_start = (state_q == S_ISSUE);
    assign task_token    = token_q;
    assign outstanding   = outstanding_w;
    assign done_count    = done_count_q;
    assign err_underflow = underflow_w;
    assign drained       = (state_q == S_IDLE) && (outstanding_w == '0) &&
                           !start_empty_n;

endmodule

// File: tb/tb_linear_layer_start_token_consumer.sv
module tb_linear_layer_start_token_consumer;

    localparam int DW  = 1;
    localparam int MAX = 2;
    localparam int CW  = 16;
    localparam int OW  = $clog2(MAX + 1);

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          start_empty_n = 1'b0;
    logic [DW-1:0] start_dout = '0;
    logic          start_read;
    logic          task_ap_start;
    logic          task_ap_ready = 1'b0;
    logic          task_ap_done = 1'b0;
    logic [DW-1:0] task_token;
    logic [OW-1:0] outstanding;
    logic [CW-1:0] done_count;
    logic          err_underflow;
    logic          drained;

    always #5 ap_clk = ~ap_clk;

    linear_layer_start_token_consumer #(
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAX),
        .CNT_WIDTH       (CW)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .start_empty_n (start_empty_n),
        .start_dout    (start_dout),
        .start_read    (start_read),
        .task_ap_start (task_ap_start),
        .task_ap_ready (task_ap_ready),
        .task_ap_done  (task_ap_done),
        .task_token    (task_token),
        .outstanding   (outstanding),
        .done_count    (done_count),
        .err_underflow (err_underflow),
        .drained       (drained)
    );

    // Behavioural token FIFO feeding the consumer
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] popped_tok;

    int n_chk  = 0;
    int n_fail = 0;
    int pops   = 0;
    int sthi   = 0;
    logic sr_s = 1'b0;
    logic st_s = 1'b0;

    typedef struct {
        logic rst;
        logic push;
        logic ptok;
        logic ready;
        logic done;
        logic e_rd;
        logic e_st;
        logic e_tok;
        int   e_out;
        int   e_dc;
        logic e_err;
        logic e_drn;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic refresh();
        start_empty_n = (fifo.size() != 0);
        start_dout    = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fifo.push_back(v);
        refresh();
    endtask

    // Snapshot the strobes at the falling edge; inputs only change just after
    // the rising edge, so these equal what the DUT sees at the next edge.
    task automatic half_a();
        @(negedge ap_clk);
        sr_s = start_read;
        st_s = task_ap_start;
    endtask

    task automatic half_b();
        @(posedge ap_clk);
        #1;
        if (sr_s) begin
            pops++;
            if (fifo.size() != 0) popped_tok = fifo.pop_front();
        end
        refresh();
        #1;
    endtask

    task automatic cyc();
        half_a();
        half_b();
    endtask

    task automatic do_reset();
        ap_rst        = 1'b1;
        task_ap_done  = 1'b0;
        task_ap_ready = 1'b0;
        fifo.delete();
        refresh();
        cyc();
        cyc();
        ap_rst = 1'b0;
    endtask

    initial begin
        //            rst push ptok rdy done | rd st tok out dc err drn
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, 1'b1};

        // Table: reset state, single token round trip, same-cycle issue+done
        for (int i = 0; i < 13; i++) begin
            ap_rst        = tbl[i].rst;
            task_ap_ready = tbl[i].ready;
            task_ap_done  = tbl[i].done;
            if (tbl[i].push) push(tbl[i].ptok);
            half_a();
            chk($sformatf("row%0d_start_read", i), 32'(start_read), 32'(tbl[i].e_rd));
            chk($sformatf("row%0d_ap_start", i), 32'(task_ap_start), 32'(tbl[i].e_st));
            chk($sformatf("row%0d_token", i), 32'(task_token), 32'(tbl[i].e_tok));
            chk($sformatf("row%0d_outstanding", i), 32'(outstanding), tbl[i].e_out);
            chk($sformatf("row%0d_done_count", i), 32'(done_count), tbl[i].e_dc);
            chk($sformatf("row%0d_err", i), 32'(err_underflow), 32'(tbl[i].e_err));
            chk($sformatf("row%0d_drained", i), 32'(drained), 32'(tbl[i].e_drn));
            half_b();
        end
        task_ap_done = 1'b0;

        // Credit limit: three tokens, no done, only two may be popped
        do_reset();
        task_ap_ready = 1'b1;
        push(1'b1);
        push(1'b0);
        push(1'b1);
        pops = 0;
        repeat (8) cyc();
        chk("credit_pops", pops, 2);
        chk("credit_outstanding", 32'(outstanding), 2);
        chk("credit_fifo_left", fifo.size(), 1);
        chk("credit_read_blocked", 32'(start_read), 0);
        task_ap_done = 1'b1;
        cyc();
        task_ap_done = 1'b0;
        pops = 0;
        cyc();
        cyc();
        chk("credit_third_pop", pops, 1);
        chk("credit_fifo_empty", fifo.size(), 0);
        chk("credit_outstanding_after", 32'(outstanding), 2);
        chk("credit_third_token", 32'(task_token), 1);

        // Ready held low for five cycles while issuing
        do_reset();
        task_ap_ready = 1'b0;
        push(1'b1);
        push(1'b0);
        cyc();
        pops = 0;
        sthi = 0;
        repeat (5) begin
            cyc();
            sthi += int'(st_s);
        end
        task_ap_ready = 1'b1;
        cyc();
        sthi += int'(st_s);
        chk("stall_start_cycles", sthi, 6);
        chk("stall_no_pop", pops, 0);
        chk("stall_outstanding", 32'(outstanding), 1);
        task_ap_ready = 1'b0;
        cyc();
        chk("stall_next_pop", pops, 1);
        chk("stall_next_token", 32'(task_token), 0);

        // Done with nothing in flight
        do_reset();
        task_ap_done = 1'b1;
        cyc();
        task_ap_done = 1'b0;
        cyc();
        chk("underflow_set", 32'(err_underflow), 1);
        chk("underflow_done_count", 32'(done_count), 0);
        chk("underflow_outstanding", 32'(outstanding), 0);
        repeat (3) cyc();
        chk("underflow_sticky", 32'(err_underflow), 1);
        ap_rst = 1'b1;
        cyc();
        chk("underflow_cleared", 32'(err_underflow), 0);
        ap_rst = 1'b0;

        // Reset while in the issue state
        do_reset();
        task_ap_ready = 1'b0;
        push(1'b1);
        push(1'b0);
        cyc();
        cyc();
        chk("rstiss_start_high", 32'(task_ap_start), 1);
        chk("rstiss_token", 32'(task_token), 1);
        ap_rst = 1'b1;
        pops = 0;
        cyc();
        chk("rstiss_start_dropped", 32'(task_ap_start), 0);
        chk("rstiss_outstanding", 32'(outstanding), 0);
        chk("rstiss_read_in_reset", 32'(start_read), 0);
        cyc();
        cyc();
        chk("rstiss_no_pop_in_reset", pops, 0);
        chk("rstiss_fifo_kept", fifo.size(), 1);
        ap_rst = 1'b0;
        cyc();
        chk("rstiss_pop_after", pops, 1);
        chk("rstiss_token_after", 32'(task_token), 0);
        chk("rstiss_start_after", 32'(task_ap_start), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
